clk_div_counter_n: RTL and testbench
====================================

# clk_div_counter_n

Parametrised up/down counter and clock-enable generator. It produces power-of-two divided waveforms from the counter bits and a programmable divide-by-M waveform from an independent divider. It sits in the clock-generation area as the general successor to the fixed 4-bit divide-by-2/4 counter. Outputs are synchronous waveforms in the `clk` domain for downstream logic; they are not buffered clocks.

## Interface
- `WIDTH`, default 4: main counter width; also the width of `clk_div_pow`.
- `DIV_W`, default 8: width of the programmable divisor.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  count enable for both the main counter and the divide-by-M divider.
- `up_dn`  in  1  main counter direction: 1 = up, 0 = down.
- `load`  in  1  synchronous load of the main counter.
- `load_val`  in  WIDTH  value loaded when `load`=1.
- `div_m`  in  DIV_W  requested divisor M.
- `count`  out  WIDTH  main counter value.
- `clk_div_pow`  out  WIDTH  equals `count`; bit k is clk/2^(k+1) while `en`=1 and `up_dn`=1.
- `clk_div_m`  out  1  divide-by-M waveform.
- `tc`  out  1  terminal count, combinational.
- `div_tick`  out  1  present only with `CLK_DIV_TICK_EN`.

## Operation
- **Main counter priority:** `rst` > `load` > `en` > hold.
  - `rst`: `count` = all ones (e.g. 4'hF).
  - `load`: `count` = `load_val`, regardless of `en` or `up_dn`.
  - `en` with `up_dn`=1: `count`+1; wraps all-ones → 0.
  - `en` with `up_dn`=0: `count`−1; wraps 0 → all-ones.
- **Terminal count:** `tc` = `en` & (`up_dn` ? `count`==all-ones : `count`==0). `load` does not mask `tc`.
- **Divider state:** internal `m_cnt` (DIV_W bits) and `m_act` (the active divisor).
  - `rst`: `m_cnt`=0, `m_act`=`div_m`, `clk_div_m`=0.
  - Bypass (`m_act` < 2): `m_cnt` held at 0, `clk_div_m` held at 0, `m_act` reloaded from `div_m` every cycle.
  - Normal (`m_act` ≥ 2), `en`=1: `m_cnt` counts 0..`m_act`−1 and wraps to 0. On the wrap cycle `m_act` reloads from `div_m`.
  - Divisor changes never truncate a period in progress.
  - `en`=0 freezes `m_cnt`, `m_act` and `clk_div_m`.
- **Divide-by-M waveform:** `clk_div_m` is registered and equals (`m_cnt` ≥ `m_act` − ⌊`m_act`/2⌋) for the current `m_cnt`.
  - High for ⌊M/2⌋ cycles and low for ⌈M/2⌉ cycles in every M enabled cycles.
  - Exact 50% duty for even M.
  - Computed at DIV_W+1 bits; no overflow for M up to 2^DIV_W − 1.
- **Independence:** `load` and direction affect only the main counter, never the divider.

## Timing
- `count`, `clk_div_m` and `m_cnt` update one edge after the inputs are sampled.
- `tc` is valid in the same cycle as `count`.
- After reset release with `en`=1 and M ≥ 2, the first `clk_div_m` rising edge occurs after ⌈M/2⌉ enabled cycles.
- Reset mid-operation: on the next edge all state returns to reset values; any partial divider period is discarded.
- `load` and `en` asserted together in the same cycle: `load` wins, with no additional increment.
- Bypass → normal transition: the new M takes effect on the first cycle after `div_m` ≥ 2 is sampled.

## Configuration
- Macro `CLK_DIV_TICK_EN`.
- **Defined:** adds registered output `div_tick`.
  - `div_tick` is high for exactly one cycle, coincident with `m_cnt` returning to 0 via a wrap.
  - It is never high for entry into `m_cnt`=0 through reset or bypass.
  - Reset value 0.
- **Undefined:** `div_tick` port and logic are absent. All other behaviour is identical.

## Structure
- **Package `clk_div_pkg`:** default `WIDTH`/`DIV_W` constants, and a function returning the high-phase start threshold M − ⌊M/2⌋.
- **Sub-module `clk_div_m_gen`:** holds `m_cnt`, `m_act`, `clk_div_m` and the optional `div_tick`. Inputs are `clk`, `rst`, `en` and `div_m`.
- **Top level:** the main counter, `tc` and `clk_div_pow` are implemented in `clk_div_counter_n` itself.

## Test plan
1. **Reset:** `rst`=1 for 2 cycles, WIDTH=4, `en`=0 → `count`=4'hF, `clk_div_m`=0, `tc`=0.
2. **Up-count wrap:** `en`=1, `up_dn`=1 for 16 cycles → `count` = F,0,1,…,E.
   - `tc` is high only while `count`=F.
   - `clk_div_pow[0]` toggles every cycle; `clk_div_pow[1]` toggles every 2 cycles.
3. **Divisor patterns:**
   - `div_m`=4 → `clk_div_m` = 0,0,1,1 repeating.
   - `div_m`=5 → 0,0,0,1,1 repeating.
   - `div_m`=1 → constant 0.
4. **Divisor change mid-period:** change `div_m` 4→6 at `m_cnt`=1 → the current period completes with 4 cycles; the next period is 0,0,0,1,1,1.
5. **Load and down-count:** `load`=1, `load_val`=2, `en`=1 → `count`=2 with no increment.
   - Then `up_dn`=0 → `count` = 1,0,F.
   - `tc` is high while `count`=0.
   - The `clk_div_m` sequence is unaffected throughout.
6. **Reset mid-period and tick:** `rst` at `m_cnt`=3 with M=6 → `m_cnt`=0 and `clk_div_m`=0 next cycle, and `div_tick` stays 0.
   - With `CLK_DIV_TICK_EN` defined, `div_tick` pulses once per 6 cycles at each wrap.

Source files
------------

// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared defaults and divide-by-M threshold helper for clk_div_counter_n.
package clk_div_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_DIV_W = 8;

  function automatic logic [31:0] hi_start(input logic [31:0] m);
    return m - (m >> 1);
  endfunction

endpackage

// File: rtl/clk_div_m_gen.sv
// clk_div_m_gen: programmable divide-by-M waveform; optional div_tick under CLK_DIV_TICK_EN.
module clk_div_m_gen
  import clk_div_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div_m,
  output logic             clk_div_m
`ifdef CLK_DIV_TICK_EN
  ,
  output logic             div_tick
`endif
);

  logic [DIV_W-1:0] m_cnt, m_act, nxt_cnt, nxt_act;
  logic             byp, wrap, nxt_out;

  // m_act only changes when m_cnt returns to 0, so a period in progress is never cut short
  always_comb begin
    byp     = m_act < DIV_W'(2);
    wrap    = !byp && m_cnt == m_act - DIV_W'(1);
    nxt_cnt = (byp || wrap) ? '0 : m_cnt + DIV_W'(1);
    nxt_act = (byp || wrap) ? div_m : m_act;
    nxt_out = nxt_act >= DIV_W'(2) &&
              {1'b0, nxt_cnt} >= (DIV_W+1)'(hi_start(32'(nxt_act)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_cnt     <= '0;
      m_act     <= div_m;
      clk_div_m <= 1'b0;
    end else if (en) begin
      m_cnt     <= nxt_cnt;
      m_act     <= nxt_act;
      clk_div_m <= nxt_out;
    end
  end

`ifdef CLK_DIV_TICK_EN
  always_ff @(posedge clk) begin
    if (rst) div_tick <= 1'b0;
    else     div_tick <= en && wrap;
  end
`endif

endmodule

// File: rtl/clk_div_counter_n.sv
// clk_div_counter_n: up/down counter with power-of-two and divide-by-M waveforms; CLK_DIV_TICK_EN adds div_tick.
module clk_div_counter_n
  import clk_div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [DIV_W-1:0] div_m,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] clk_div_pow,
  output logic             clk_div_m,
  output logic             tc
`ifdef CLK_DIV_TICK_EN
  ,
  output logic             div_tick
`endif
);

  always_ff @(posedge clk) begin
    if (rst)       count <= '1;
    else if (load) count <= load_val;
    else if (en)   count <= up_dn ? count + WIDTH'(1) : count - WIDTH'(1);
  end

  always_comb begin
    tc          = en && (up_dn ? &count : ~|count);
    clk_div_pow = count;
  end

  clk_div_m_gen #(.DIV_W(DIV_W)) u_m_gen (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .div_m     (div_m),
    .clk_div_m (clk_div_m)
`ifdef CLK_DIV_TICK_EN
    ,
    .div_tick  (div_tick)
`endif
  );

endmodule

// File: tb/tb_clk_div_counter_n.sv
// tb_clk_div_counter_n: randomized self-checking bench against a queue-based waveform model; CLK_DIV_TICK_EN aware.
module tb_clk_div_counter_n;

  logic       clk = 1'b0;
  logic       rst, en, up_dn, load;
  logic [3:0] load_val, count, clk_div_pow;
  logic [7:0] div_m;
  logic       clk_div_m, tc;
`ifdef CLK_DIV_TICK_EN
  logic       div_tick;
`endif

  clk_div_counter_n dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .up_dn       (up_dn),
    .load        (load),
    .load_val    (load_val),
    .div_m       (div_m),
    .count       (count),
    .clk_div_pow (clk_div_pow),
    .clk_div_m   (clk_div_m),
    .tc          (tc)
`ifdef CLK_DIV_TICK_EN
    ,
    .div_tick    (div_tick)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: counter value as an integer, divider as a queue of upcoming waveform samples
  int mc;
  bit mq[$];
  bit mcur, mbyp, mtick;
  int nticks;

  function automatic void load_period(int m);
    for (int i = 0; i < m; i++) mq.push_back(i >= (m + 1) / 2);
  endfunction

  task automatic step(input bit r, input bit e, input bit u, input bit l,
                      input logic [3:0] lv, input logic [7:0] dm);
    bit exp_tc;
    rst = r; en = e; up_dn = u; load = l; load_val = lv; div_m = dm;
    #1;
    exp_tc = e && (u ? mc == 15 : mc == 0);
    checks++;
    if (tc !== exp_tc) begin
      errors++;
      $display("FAIL tc got %0b exp %0b (count model %0d)", tc, exp_tc, mc);
    end
    @(posedge clk);
    mtick = 0;
    if (r) begin
      mc = 15; mq.delete(); mcur = 0; mbyp = dm < 2;
      if (!mbyp) begin load_period(dm); mcur = mq.pop_front(); end
    end else begin
      if (l) mc = lv;
      else if (e) mc = u ? (mc + 1) % 16 : (mc + 15) % 16;
      if (e) begin
        if (mbyp || mq.size() == 0) begin
          mtick = !mbyp;
          mbyp  = dm < 2;
          mcur  = 0;
          if (!mbyp) begin load_period(dm); mcur = mq.pop_front(); end
        end else mcur = mq.pop_front();
      end
    end
    #1;
    checks += 3;
    if (count !== 4'(mc)) begin
      errors++;
      $display("FAIL count got %0h exp %0h", count, mc);
    end
    if (clk_div_pow !== 4'(mc)) begin
      errors++;
      $display("FAIL clk_div_pow got %0h exp %0h", clk_div_pow, mc);
    end
    if (clk_div_m !== mcur) begin
      errors++;
      $display("FAIL clk_div_m got %0b exp %0b (div_m %0d)", clk_div_m, mcur, dm);
    end
`ifdef CLK_DIV_TICK_EN
    checks++;
    if (div_tick) nticks++;
    if (div_tick !== mtick) begin
      errors++;
      $display("FAIL div_tick got %0b exp %0b", div_tick, mtick);
    end
`endif
    @(negedge clk);
  endtask

  task automatic test_reset();
    step(1, 0, 1, 0, 4'h0, 8'd4);
    step(1, 0, 1, 0, 4'h0, 8'd4);
    checks++;
    if (count !== 4'hF || clk_div_m !== 1'b0 || tc !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got count %0h cdm %0b tc %0b exp F 0 0", count, clk_div_m, tc);
    end
  endtask

  task automatic test_up_wrap();
    logic [3:0] prev;
    for (int i = 0; i < 16; i++) begin
      prev = count;
      step(0, 1, 1, 0, 4'h0, 8'd4);
      checks++;
      if (clk_div_pow[0] === prev[0]) begin
        errors++;
        $display("FAIL pow0_toggle got %0b prev %0b", clk_div_pow[0], prev[0]);
      end
    end
  endtask

  task automatic test_divisors();
    int ms[3] = '{4, 5, 1};
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 1, 0, 4'h0, 8'(ms[k]));
      for (int i = 1; i < 12; i++) begin
        step(0, 1, 1, 0, 4'h0, 8'(ms[k]));
        checks++;
        if (clk_div_m !== (ms[k] >= 2 && (i % ms[k]) >= (ms[k] + 1) / 2)) begin
          errors++;
          $display("FAIL pattern_m%0d cycle %0d got %0b", ms[k], i, clk_div_m);
        end
      end
    end
  endtask

  task automatic test_div_change();
    bit exp[8] = '{1, 1, 0, 0, 0, 1, 1, 1};
    step(1, 0, 1, 0, 4'h0, 8'd4);
    step(0, 1, 1, 0, 4'h0, 8'd4);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 1, 0, 4'h0, 8'd6);
      checks++;
      if (clk_div_m !== exp[i]) begin
        errors++;
        $display("FAIL div_change cycle %0d got %0b exp %0b", i, clk_div_m, exp[i]);
      end
    end
  endtask

  task automatic test_load_down();
    step(0, 1, 1, 1, 4'h2, 8'd6);
    checks++;
    if (count !== 4'h2) begin
      errors++;
      $display("FAIL load_no_inc got %0h exp 2", count);
    end
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 4'h0, 8'd6);
  endtask

  task automatic test_reset_mid();
    step(1, 0, 1, 0, 4'h0, 8'd6);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 4'h0, 8'd6);
    step(1, 1, 1, 0, 4'h0, 8'd6);
    checks++;
    if (clk_div_m !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got %0b exp 0", clk_div_m);
    end
`ifdef CLK_DIV_TICK_EN
    nticks = 0;
`endif
    for (int i = 0; i < 12; i++) step(0, 1, 1, 0, 4'h0, 8'd6);
`ifdef CLK_DIV_TICK_EN
    checks++;
    if (nticks != 2) begin
      errors++;
      $display("FAIL tick_count got %0d exp 2", nticks);
    end
`endif
  endtask

  task automatic test_random();
    logic [7:0] dm;
    for (int i = 0; i < 400; i++) begin
      dm = ($urandom_range(0, 19) == 0) ? 8'd255 : 8'($urandom_range(0, 9));
      step($urandom_range(0, 49) == 0, $urandom_range(0, 4) != 0, 1'($urandom),
           $urandom_range(0, 9) == 0, 4'($urandom), dm);
    end
  endtask

  initial begin
    rst = 1; en = 0; up_dn = 1; load = 0; load_val = '0; div_m = 8'd4;
    mc = 15; mcur = 0; mbyp = 0; mtick = 0; nticks = 0;
    @(negedge clk);
    test_reset();
    test_up_wrap();
    test_divisors();
    test_div_change();
    test_load_down();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
